// File: rtl/multi_cycle_ctrl_pkg.sv
// Package: mc_ctrl_pkg
// Shared definitions for the multi-cycle controller: the state encoding,
// the opcodes it decodes, and the datapath select encodings it drives.
package mc_ctrl_pkg;

  // Controller states. The numeric values are visible on state_o for debug.
  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_IF   = 4'd1,
    S_ID   = 4'd2,
    S_EXR  = 4'd3,
    S_EXI  = 4'd4,
    S_WBR  = 4'd5,
    S_WBI  = 4'd6,
    S_ADDR = 4'd7,
    S_MRD  = 4'd8,
    S_MWR  = 4'd9,
    S_WBM  = 4'd10,
    S_BR   = 4'd11,
    S_JMP  = 4'd12,
    S_HALT = 4'd13
  } state_e;

  // Opcodes taken from IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  // ALUOp codes handed to ALU_Ctrl
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;

  // ALU operand B select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory request open and wait for mem_ready_i
  function automatic logic is_mem_wait(input state_e s);
    return (s == S_IF) || (s == S_MRD) || (s == S_MWR);
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Interface: multi_cycle_ctrl_if
// Bundles the controller's decode inputs, memory handshake and every
// datapath enable/select. master = controller, slave = datapath/memory side.
interface multi_cycle_ctrl_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
);

  logic [OP_W-1:0]    instr_op_i;
  logic               zero_i;
  logic               mem_ready_i;
  logic               pc_write_o;
  logic               ir_write_o;
  logic               i_or_d_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic               mem_to_reg_o;
  logic               reg_write_o;
  logic               reg_dst_o;
  logic               alu_src_a_o;
  logic [1:0]         alu_src_b_o;
  logic [ALUOP_W-1:0] alu_op_o;
  logic [1:0]         pc_source_o;
  logic               halt_o;
  logic [3:0]         state_o;
  logic [31:0]        instret_o;

  modport master (
    input  instr_op_i, zero_i, mem_ready_i,
    output pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o,
           mem_to_reg_o, reg_write_o, reg_dst_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_source_o, halt_o, state_o, instret_o
  );

  modport slave (
    output instr_op_i, zero_i, mem_ready_i,
    input  pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o,
           mem_to_reg_o, reg_write_o, reg_dst_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, pc_source_o, halt_o, state_o, instret_o
  );

endinterface

// File: rtl/multi_cycle_ctrl_next_state.sv
// Module: mc_next_state
// Purely combinational next-state logic for the multi-cycle controller.
// A timeout always wins over a late mem_ready_i in the waiting states.
module mc_next_state
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  state_e          state_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            mem_ready_i,
  input  logic            timeout_i,
  output state_e          next_state_o
);

  // Sequence IF/ID/EX/MEM/WB; unknown opcodes and timeouts park in HALT
  always_comb begin
    next_state_o = state_i;
    case (state_i)
      S_RST: next_state_o = S_IF;
      S_IF: begin
        if (timeout_i)        next_state_o = S_HALT;
        else if (mem_ready_i) next_state_o = S_ID;
      end
      S_ID: begin
        case (op_i)
          OP_W'(OP_RTYPE):             next_state_o = S_EXR;
          OP_W'(OP_ADDI), OP_W'(OP_SLTI): next_state_o = S_EXI;
          OP_W'(OP_LW), OP_W'(OP_SW):  next_state_o = S_ADDR;
          OP_W'(OP_BEQ), OP_W'(OP_BNE): next_state_o = S_BR;
          OP_W'(OP_J):                 next_state_o = S_JMP;
          default:                     next_state_o = S_HALT;
        endcase
      end
      S_EXR: next_state_o = S_WBR;
      S_EXI: next_state_o = S_WBI;
      S_WBR: next_state_o = S_IF;
      S_WBI: next_state_o = S_IF;
      S_ADDR: begin
        if (op_i == OP_W'(OP_LW))      next_state_o = S_MRD;
        else if (op_i == OP_W'(OP_SW)) next_state_o = S_MWR;
        else                           next_state_o = S_HALT;
      end
      S_MRD: begin
        if (timeout_i)        next_state_o = S_HALT;
        else if (mem_ready_i) next_state_o = S_WBM;
      end
      S_MWR: begin
        if (timeout_i)        next_state_o = S_HALT;
        else if (mem_ready_i) next_state_o = S_IF;
      end
      S_WBM:  next_state_o = S_IF;
      S_BR:   next_state_o = S_IF;
      S_JMP:  next_state_o = S_IF;
      S_HALT: next_state_o = S_HALT;
      default: next_state_o = S_HALT;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Module: multi_cycle_ctrl
// Multi-cycle control FSM sharing one memory and one ALU across
// IF/ID/EX/MEM/WB. Holds the state register, the memory wait counter,
// the output decode and, when PERF_CNT_EN is defined, a retired-instruction
// counter (otherwise instret_o is tied to zero).
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int TIMEOUT = 15
) (
  input logic               clk_i,
  input logic               rst_i,
  multi_cycle_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout;

  logic               pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic               mem_to_reg, reg_write, reg_dst, alu_src_a;
  logic [1:0]         alu_src_b, pc_source;
  logic [ALUOP_W-1:0] alu_op;

  // The wait counter only ever reaches TIMEOUT in a waiting state
  assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT));

  mc_next_state #(.OP_W(OP_W)) u_next_state (
    .state_i      (state_q),
    .op_i         (bus.instr_op_i),
    .mem_ready_i  (bus.mem_ready_i),
    .timeout_i    (timeout),
    .next_state_o (state_d)
  );

  // Count stalled cycles in the current waiting state; any move restarts it
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q)
      wait_cnt_d = '0;
    else if (is_mem_wait(state_q) && !bus.mem_ready_i)
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  // State register and wait counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_RST;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Moore decode of the datapath controls, gated by ready/zero/timeout
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALUOP_W'(ALU_ADD);
    pc_source  = PCSRC_ALU;
    case (state_q)
      S_IF: begin
        mem_read  = ~timeout;
        alu_src_b = SRCB_FOUR;
        pc_write  = bus.mem_ready_i & ~timeout;
        ir_write  = bus.mem_ready_i & ~timeout;
      end
      S_ID: begin
        alu_src_b = SRCB_IMM_SH2;
      end
      S_EXR: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALU_FUNCT);
      end
      S_EXI: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (bus.instr_op_i == OP_W'(OP_SLTI)) ? ALUOP_W'(ALU_SLT)
                                                       : ALUOP_W'(ALU_ADD);
      end
      S_WBR: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_WBI: begin
        reg_write = 1'b1;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MRD: begin
        i_or_d   = 1'b1;
        mem_read = ~timeout;
      end
      S_MWR: begin
        i_or_d    = 1'b1;
        mem_write = ~timeout;
      end
      S_WBM: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_BR: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALU_SUB);
        pc_source = PCSRC_ALUOUT;
        pc_write  = (bus.instr_op_i == OP_W'(OP_BNE)) ? ~bus.zero_i : bus.zero_i;
      end
      S_JMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc_write_o   = pc_write;
  assign bus.ir_write_o   = ir_write;
  assign bus.i_or_d_o     = i_or_d;
  assign bus.mem_read_o   = mem_read;
  assign bus.mem_write_o  = mem_write;
  assign bus.mem_to_reg_o = mem_to_reg;
  assign bus.reg_write_o  = reg_write;
  assign bus.reg_dst_o    = reg_dst;
  assign bus.alu_src_a_o  = alu_src_a;
  assign bus.alu_src_b_o  = alu_src_b;
  assign bus.alu_op_o     = alu_op;
  assign bus.pc_source_o  = pc_source;
  assign bus.halt_o       = (state_q == S_HALT);
  assign bus.state_o      = state_q;

`ifdef PERF_CNT_EN
  logic [31:0] instret_q, instret_d;

  // An instruction retires when its last state hands back to IF
  always_comb begin
    instret_d = instret_q;
    if ((state_d == S_IF) &&
        (state_q inside {S_WBR, S_WBI, S_WBM, S_MWR, S_BR, S_JMP}))
      instret_d = instret_q + 32'd1;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign bus.instret_o = instret_q;
`else
  assign bus.instret_o = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Testbench: tb_multi_cycle_ctrl
// Drives instruction-level transactions with random opcodes, memory wait
// lengths and zero flags, and compares every cycle against the expected
// per-instruction state walk and control word. PERF_CNT_EN selects the
// expected instret_o behaviour.
module tb_multi_cycle_ctrl;
  import mc_ctrl_pkg::*;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 3;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       halt;
  } ctrl_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   retired      = 0;

  logic [5:0] legal_ops [8] = '{OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW,
                                OP_SW, OP_BEQ, OP_BNE, OP_J};

  multi_cycle_ctrl_if #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) bus ();

  multi_cycle_ctrl #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  ctrl_t obs;
  assign obs = {bus.pc_write_o, bus.ir_write_o, bus.i_or_d_o, bus.mem_read_o,
                bus.mem_write_o, bus.mem_to_reg_o, bus.reg_write_o,
                bus.reg_dst_o, bus.alu_src_a_o, bus.alu_src_b_o,
                bus.alu_op_o, bus.pc_source_o, bus.halt_o};

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic rand_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW,
                      OP_BEQ, OP_BNE, OP_J};
  endfunction

  function automatic logic [31:0] exp_instret();
`ifdef PERF_CNT_EN
    return 32'(retired);
`else
    return 32'd0;
`endif
  endfunction

  // One clock: drive ready away from the edge, then check state and controls
  task automatic applyStimulus(input state_e st, input logic rdy,
                               input ctrl_t exp, input string tag);
    @(negedge clk_i);
    bus.mem_ready_i = rdy;
    #1;
    checkOutput({tag, "_state"}, 32'(bus.state_o), 32'(st));
    checkOutput({tag, "_ctrl"}, 32'(obs), 32'(exp));
  endtask

  // A waiting state: w stalled cycles, then either ready or the timeout cycle
  task automatic wait_phase(input state_e st, input int w, input ctrl_t busy,
                            input ctrl_t done, input string tag,
                            output logic timed_out);
    ctrl_t t;
    timed_out = 1'b0;
    for (int i = 0; i < w && i < TIMEOUT; i++)
      applyStimulus(st, 1'b0, busy, tag);
    if (w >= TIMEOUT) begin
      t = busy;
      t.mem_read  = 1'b0;
      t.mem_write = 1'b0;
      applyStimulus(st, rand_bit(), t, {tag, "_tmo"});
      timed_out = 1'b1;
    end else begin
      applyStimulus(st, 1'b1, done, tag);
    end
  endtask

  task automatic halt_check(input int n);
    ctrl_t c;
    c = '0;
    c.halt = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.zero_i = rand_bit();
      applyStimulus(S_HALT, rand_bit(), c, "halt");
    end
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    rst_i   = 1'b1;
    retired = 0;
    #1;
    checkOutput("rel_state", 32'(bus.state_o), 32'(S_RST));
    checkOutput("rel_ctrl", 32'(obs), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checkOutput("rst_state", 32'(bus.state_o), 32'(S_RST));
    checkOutput("rst_ctrl", 32'(obs), 32'd0);
    checkOutput("rst_instret", bus.instret_o, 32'd0);
    release_reset();
  endtask

  // Full instruction from its first fetch cycle to its hand-back to IF
  task automatic run_instr(input logic [5:0] op, input int if_wait,
                           input int mem_wait, input logic zero,
                           output logic halted);
    ctrl_t busy, done, c;
    logic  tmo;
    halted = 1'b0;
    bus.instr_op_i = op;
    bus.zero_i     = zero;
    busy = '0;
    busy.mem_read  = 1'b1;
    busy.alu_src_b = 2'b01;
    done = busy;
    done.pc_write = 1'b1;
    done.ir_write = 1'b1;
    wait_phase(S_IF, if_wait, busy, done, "fetch", tmo);
    checkOutput("instret", bus.instret_o, exp_instret());
    if (tmo) begin
      halted = 1'b1;
      return;
    end
    c = '0;
    c.alu_src_b = 2'b11;
    applyStimulus(S_ID, rand_bit(), c, "decode");
    case (op)
      OP_RTYPE: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b010;
        applyStimulus(S_EXR, rand_bit(), c, "exr");
        c = '0; c.reg_dst = 1'b1; c.reg_write = 1'b1;
        applyStimulus(S_WBR, rand_bit(), c, "wbr");
        retired++;
      end
      OP_ADDI, OP_SLTI: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        c.alu_op = (op == OP_SLTI) ? 3'b011 : 3'b000;
        applyStimulus(S_EXI, rand_bit(), c, "exi");
        c = '0; c.reg_write = 1'b1;
        applyStimulus(S_WBI, rand_bit(), c, "wbi");
        retired++;
      end
      OP_LW, OP_SW: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        applyStimulus(S_ADDR, rand_bit(), c, "addr");
        busy = '0;
        busy.i_or_d = 1'b1;
        if (op == OP_LW) busy.mem_read  = 1'b1;
        else             busy.mem_write = 1'b1;
        wait_phase((op == OP_LW) ? S_MRD : S_MWR, mem_wait, busy, busy,
                   (op == OP_LW) ? "mrd" : "mwr", tmo);
        if (tmo) begin
          halted = 1'b1;
        end else if (op == OP_LW) begin
          c = '0; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
          applyStimulus(S_WBM, rand_bit(), c, "wbm");
          retired++;
        end else begin
          retired++;
        end
      end
      OP_BEQ, OP_BNE: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_source = 2'b01;
        c.pc_write = (op == OP_BEQ) ? zero : ~zero;
        applyStimulus(S_BR, rand_bit(), c, "br");
        retired++;
      end
      OP_J: begin
        c = '0; c.pc_source = 2'b10; c.pc_write = 1'b1;
        applyStimulus(S_JMP, rand_bit(), c, "jmp");
        retired++;
      end
      default: halted = 1'b1;
    endcase
  endtask

  // Reset dropped while a store is still waiting on memory
  task automatic mid_sw_reset();
    ctrl_t c;
    bus.instr_op_i = OP_SW;
    c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
    c.pc_write = 1'b1; c.ir_write = 1'b1;
    applyStimulus(S_IF, 1'b1, c, "sw_fetch");
    c = '0; c.alu_src_b = 2'b11;
    applyStimulus(S_ID, 1'b0, c, "sw_decode");
    c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    applyStimulus(S_ADDR, 1'b0, c, "sw_addr");
    c = '0; c.i_or_d = 1'b1; c.mem_write = 1'b1;
    applyStimulus(S_MWR, 1'b0, c, "sw_wait");
    applyStimulus(S_MWR, 1'b0, c, "sw_wait");
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("midrst_mem_write", 32'(bus.mem_write_o), 32'd0);
    checkOutput("midrst_state", 32'(bus.state_o), 32'(S_RST));
    checkOutput("midrst_instret", bus.instret_o, 32'd0);
    release_reset();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic       h;
    logic [5:0] op;
    int         iw, mw;
    bus.instr_op_i  = '0;
    bus.zero_i      = 1'b0;
    bus.mem_ready_i = 1'b0;
    #2 rst_i = 1'b0;
    $display("[TB] start");
    repeat (2) @(negedge clk_i);
    do_reset();

    run_instr(OP_J,     0, 0, 1'b0, h);
    run_instr(OP_SW,    0, 0, 1'b0, h);
    run_instr(OP_ADDI,  0, 0, 1'b0, h);
    run_instr(OP_RTYPE, 0, 0, 1'b0, h);
    run_instr(OP_LW,    0, 3, 1'b0, h);
    run_instr(OP_BEQ,   0, 0, 1'b1, h);
    run_instr(OP_BNE,   0, 0, 1'b1, h);
    run_instr(OP_SLTI,  2, 0, 1'b0, h);
    run_instr(6'h3F,    0, 0, 1'b0, h);
    halt_check(20);
    do_reset();
    run_instr(OP_J, TIMEOUT, 0, 1'b0, h);
    halt_check(3);
    do_reset();
    run_instr(OP_SW, 0, TIMEOUT, 1'b0, h);
    halt_check(3);
    do_reset();
    run_instr(OP_J, 0, 0, 1'b0, h);
    mid_sw_reset();

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 14) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 7)];
      end
      iw = ($urandom_range(0, 39) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                        : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 29) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                        : int'($urandom_range(0, 4));
      run_instr(op, iw, mw, rand_bit(), h);
      if (h) begin
        halt_check(3);
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
